// File: rtl/pwm_duty_ramp_pkg.sv
// Shared PWM definitions: duty width, default ramp pacing and ramp FSM states.
package pwm_duty_ramp_pkg;

    localparam int unsigned DUTY_W               = 8;
    localparam int unsigned PERIODS_PER_STEP_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } ramp_state_e;

endpackage

// File: rtl/pwm_duty_ramp_period_timer.sv
// Free-running PWM period counter with end-of-period and start-of-period decode.
module pwm_period_timer
    import pwm_duty_ramp_pkg::*;
(
    input  logic clkin_i,
    input  logic reset_i,
    output logic boundary_o,
    output logic period_start_o
);

    logic [DUTY_W-1:0] pcnt_q;
    logic [DUTY_W-1:0] pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
    end

    always_ff @(posedge clkin_i or posedge reset_i) begin
        if (reset_i) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign boundary_o     = (pcnt_q == '1);
    assign period_start_o = (pcnt_q == '0);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Ramps the PWM duty toward a requested target, one step every PERIODS_PER_STEP periods.
module pwm_duty_ramp
    import pwm_duty_ramp_pkg::*;
#(
    parameter int unsigned PERIODS_PER_STEP = PERIODS_PER_STEP_DEF
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic [DUTY_W-1:0] step_size,
    input  logic              target_valid,
    output logic              target_ready,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              ramp_busy,
    output logic              period_start
);

    localparam logic [DUTY_W-1:0] DIV_LAST = DUTY_W'(PERIODS_PER_STEP - 1);

    ramp_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [DUTY_W-1:0] stp_q, stp_d;
    logic [DUTY_W-1:0] div_q, div_d;
    logic              boundary;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W-1:0] dn_gap;
    logic [DUTY_W-1:0] duty_step;

    pwm_period_timer u_timer (
        .clkin_i        (clkin),
        .reset_i        (reset),
        .boundary_o     (boundary),
        .period_start_o (period_start)
    );

    // 9-bit sum keeps the ramp-up clamp correct near 255; the down gap is only used when duty_q > tgt_q.
    always_comb begin
        up_sum    = {1'b0, duty_q} + {1'b0, stp_q};
        dn_gap    = duty_q - tgt_q;
        duty_step = duty_q;
        if (state_q == RAMP_UP) begin
            duty_step = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[DUTY_W-1:0];
        end else if (state_q == RAMP_DOWN) begin
            duty_step = (dn_gap <= stp_q) ? tgt_q : duty_q - stp_q;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        stp_d   = stp_q;
        div_d   = div_q;
        case (state_q)
            IDLE: begin
                if (target_valid) begin
                    tgt_d = target_duty;
                    stp_d = (step_size == '0) ? DUTY_W'(1) : step_size;
                    div_d = '0;
                    if (target_duty > duty_q) begin
                        state_d = RAMP_UP;
                    end else if (target_duty < duty_q) begin
                        state_d = RAMP_DOWN;
                    end
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (boundary) begin
                    if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        duty_d = duty_step;
                        if (duty_step == tgt_q) begin
                            state_d = IDLE;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            stp_q   <= DUTY_W'(1);
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            stp_q   <= stp_d;
            div_q   <= div_d;
        end
    end

    assign duty_cycle   = duty_q;
    assign target_ready = (state_q == IDLE);
    assign ramp_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: expected duty changes (value and edge) are queued at request time.
module tb_pwm_duty_ramp;

    localparam int PPS = 4;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] target_duty = '0;
    logic [7:0] step_size = '0;
    logic       target_valid = 1'b0;
    logic       target_ready;
    logic [7:0] duty_cycle;
    logic       ramp_busy;
    logic       period_start;

    pwm_duty_ramp #(.PERIODS_PER_STEP(PPS)) dut (
        .clkin        (clkin),
        .reset        (reset),
        .target_duty  (target_duty),
        .step_size    (step_size),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .duty_cycle   (duty_cycle),
        .ramp_busy    (ramp_busy),
        .period_start (period_start)
    );

    always #5 clkin = ~clkin;

    // Number of rising edges since reset release; edge n sees internal count n%256 before it.
    int ncnt = 0;
    always @(posedge clkin) begin
        if (reset) ncnt <= 0;
        else       ncnt <= ncnt + 1;
    end

    typedef struct {
        int at_edge;
        int duty;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   mdl_duty = 0;
    int   mdl_end  = 0;

    function automatic void check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Reference: k-th boundary after acceptance is the k-th edge with index%256==255 strictly after it;
    // duty moves every PPS boundaries by the step, clamped at the target.
    task automatic request(input int tgt, input int stp);
        int a, v, s, b1, j;
        @(negedge clkin);
        check("ready_before_request", target_ready, 1);
        a = ncnt;
        target_duty  = tgt[7:0];
        step_size    = stp[7:0];
        target_valid = 1'b1;
        s  = (stp == 0) ? 1 : stp;
        b1 = a + ((255 - (a % 256) + 256) % 256);
        if (b1 == a) b1 = a + 256;
        v = mdl_duty;
        j = 0;
        mdl_end = a;
        while (v != tgt) begin
            j++;
            if (tgt > v) v = (v + s > tgt) ? tgt : v + s;
            else         v = (v - tgt <= s) ? tgt : v - s;
            mdl_end = b1 + (PPS * j - 1) * 256;
            sb.push_back('{mdl_end, v});
        end
        mdl_duty = v;
        @(negedge clkin);
        target_valid = 1'b0;
        check("busy_after_accept", ramp_busy, (mdl_end != a) ? 1 : 0);
        check("ready_after_accept", target_ready, (mdl_end != a) ? 0 : 1);
    endtask

    task automatic wait_done(input string name);
        while (ncnt <= mdl_end + 2) @(negedge clkin);
        check({name, "_pending"}, sb.size(), 0);
        check({name, "_ready"}, target_ready, 1);
        check({name, "_busy"}, ramp_busy, 0);
        check({name, "_duty"}, duty_cycle, mdl_duty);
    endtask

    // Monitor: every duty change must match the head of the scoreboard in value and edge index.
    initial begin
        int   last;
        exp_t e;
        last = 0;
        forever begin
            @(negedge clkin);
            if (reset) begin
                last = duty_cycle;
            end else begin
                check("period_start", period_start, (ncnt % 256 == 0) ? 1 : 0);
                if (duty_cycle != last) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_duty_change: got %0d expected %0d (t=%0t)",
                                 duty_cycle, last, $time);
                    end else begin
                        e = sb.pop_front();
                        check("duty_value", duty_cycle, e.duty);
                        check("duty_edge", ncnt - 1, e.at_edge);
                    end
                    last = duty_cycle;
                end
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1);
    end

    initial begin
        int e6, t, s;
        repeat (3) @(negedge clkin);
        check("reset_duty", duty_cycle, 0);
        check("reset_ready", target_ready, 1);
        check("reset_busy", ramp_busy, 0);
        check("reset_period_start", period_start, 1);
        #1 reset = 1'b0;

        request(10, 3);
        wait_done("ramp_up");

        // Accept exactly on a boundary edge.
        while ((ncnt + 1) % 256 != 255) @(negedge clkin);
        request(0, 4);
        wait_done("ramp_down");

        request(250, 255);
        wait_done("to_250");
        request(255, 10);
        wait_done("saturate");
        request(0, 255);
        wait_done("to_0");
        request(2, 0);
        wait_done("step_zero");

        request(2, 7);
        wait_done("equal_target");

        request(40, 20);
        target_duty  = 8'd200;
        step_size    = 8'd1;
        target_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (100) @(negedge clkin);
            check("held_valid_ready", target_ready, 0);
        end
        target_valid = 1'b0;
        wait_done("ignored_request");

        request(0, 255);
        wait_done("back_to_0");

        request(10, 3);
        e6 = sb[1].at_edge;
        while (ncnt <= e6 + 50) @(negedge clkin);
        check("pre_reset_duty", duty_cycle, 6);
        #2 reset = 1'b1;
        #1;
        check("async_reset_duty", duty_cycle, 0);
        check("async_reset_ready", target_ready, 1);
        check("async_reset_busy", ramp_busy, 0);
        check("async_reset_period_start", period_start, 1);
        sb.delete();
        mdl_duty = 0;
        repeat (3) @(negedge clkin);
        #1 reset = 1'b0;
        mdl_end = 0;
        @(negedge clkin);
        check("post_reset_ready", target_ready, 1);
        check("post_reset_busy", ramp_busy, 0);
        check("post_reset_duty", duty_cycle, 0);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 300)) @(negedge clkin);
            t = $urandom_range(0, 255);
            s = $urandom_range(64, 255);
            request(t, s);
            wait_done("random");
        end

        repeat (10) @(negedge clkin);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
